// File: rtl/parity_stream_if.sv
// Stream-side bundle of the parity unit: word input with optional received parity,
// and per-word, per-frame and error results back to the source side.
interface parity_stream_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_par;
    logic             chk_en;
    logic             frame_clr;
    logic             word_valid;
    logic             word_par;
    logic             frame_valid;
    logic [WIDTH-1:0] frame_lrc;
    logic             frame_par;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    modport master (
        output in_valid, in_data, in_par, chk_en, frame_clr,
        input  word_valid, word_par, frame_valid, frame_lrc, frame_par, err, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, in_par, chk_en, frame_clr,
        output word_valid, word_par, frame_valid, frame_lrc, frame_par, err, err_cnt, busy
    );
endinterface

// File: rtl/parity_stream_unit.sv
// Per-word parity, optional received-parity check with saturating error count, and
// longitudinal (column-XOR) check word over fixed-length frames.
module parity_stream_unit #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0,
    parameter int ERR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    parity_stream_if.slave    bus
);
    localparam int   CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic ODD_B = (ODD != 0);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state_q, state_d, st_base;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_base;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               word_valid_q, word_par_q;
    logic               frame_valid_q, frame_par_q;
    logic [WIDTH-1:0]   frame_lrc_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               frame_fire;
    logic [WIDTH-1:0]   lrc_final;
    logic               p_word, mismatch;

    assign p_word    = (^bus.in_data) ^ ODD_B;
    assign mismatch  = bus.chk_en & bus.in_valid & (bus.in_par != p_word);
    assign lrc_final = acc_q ^ bus.in_data;

    always_comb begin
        // frame_clr wipes the running frame first; a same-cycle word then starts a new one
        st_base    = bus.frame_clr ? IDLE : state_q;
        acc_base   = bus.frame_clr ? '0   : acc_q;
        cnt_base   = bus.frame_clr ? '0   : cnt_q;
        state_d    = st_base;
        acc_d      = acc_base;
        cnt_d      = cnt_base;
        frame_fire = 1'b0;
        if (bus.in_valid) begin
            case (st_base)
                IDLE: begin
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
                ACCUM: begin
                    if (cnt_base == CNT_W'(FRAME_LEN - 1)) begin
                        frame_fire = 1'b1;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        acc_d = acc_base ^ bus.in_data;
                        cnt_d = cnt_base + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid_q  <= 1'b0;
            word_par_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_lrc_q   <= '0;
            frame_par_q   <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            word_valid_q  <= bus.in_valid;
            frame_valid_q <= frame_fire;
            err_q         <= mismatch;
            if (bus.in_valid) word_par_q <= p_word;
            if (frame_fire) begin
                frame_lrc_q <= lrc_final;
                frame_par_q <= (^lrc_final) ^ ODD_B;
            end
            if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign bus.word_valid  = word_valid_q;
    assign bus.word_par    = word_par_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_lrc   = frame_lrc_q;
    assign bus.frame_par   = frame_par_q;
    assign bus.err         = err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.busy        = (state_q == ACCUM);
endmodule

// File: tb/tb_parity_stream_unit.sv
// Drives an even-parity and an odd-parity instance with the same stream and
// checks both against expectations queued at drive time.
module tb_parity_stream_unit;
    localparam int W  = 8;
    localparam int FL = 4;
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_stream_if #(.WIDTH(W), .ERR_W(EW)) b0 ();
    parity_stream_if #(.WIDTH(W), .ERR_W(EW)) b1 ();

    parity_stream_unit #(.WIDTH(W), .FRAME_LEN(FL), .ODD(0), .ERR_W(EW)) dut0 (
        .clk(clk), .rst(rst), .bus(b0));
    parity_stream_unit #(.WIDTH(W), .FRAME_LEN(FL), .ODD(1), .ERR_W(EW)) dut1 (
        .clk(clk), .rst(rst), .bus(b1));

    typedef struct {int cyc; logic p0; logic p1; logic e0; logic e1;} wexp_t;
    typedef struct {int cyc; logic [W-1:0] lrc;} fexp_t;

    wexp_t wq[$];
    fexp_t fq[$];
    wexp_t we;
    fexp_t fe;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // model state as it must look after the next clock edge
    logic [W-1:0]  macc;
    int            mcnt;
    logic [EW-1:0] ecnt0, ecnt1;
    logic          ebusy;
    // held output values
    logic          hw0, hw1, hfp0, hfp1;
    logic [W-1:0]  hlrc;
    logic          wv, fv, xe0, xe1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic p,
                         input logic ce, input logic clr);
        b0.in_valid = v;  b0.in_data = d;  b0.in_par = p;  b0.chk_en = ce;  b0.frame_clr = clr;
        b1.in_valid = v;  b1.in_data = d;  b1.in_par = p;  b1.chk_en = ce;  b1.frame_clr = clr;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic p,
                        input logic ce, input logic clr);
        logic p0, p1, e0, e1;
        @(negedge clk);
        rst = 1'b0;
        drive(v, d, p, ce, clr);
        if (clr) begin
            macc = '0;
            mcnt = 0;
        end
        if (v) begin
            p0 = ^d;
            p1 = ~(^d);
            e0 = ce && (p != p0);
            e1 = ce && (p != p1);
            if (e0 && ecnt0 != 4'hF) ecnt0++;
            if (e1 && ecnt1 != 4'hF) ecnt1++;
            wq.push_back('{cyc + 1, p0, p1, e0, e1});
            macc = (mcnt == 0) ? d : (macc ^ d);
            mcnt++;
            if (mcnt == FL) begin
                fq.push_back('{cyc + 1, macc});
                macc = '0;
                mcnt = 0;
            end
        end
        ebusy = (mcnt != 0);
    endtask

    // reset with every other input active to show it is overridden
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        macc = '0;  mcnt = 0;  ecnt0 = '0;  ecnt1 = '0;  ebusy = 1'b0;
        hw0 = 1'b0; hw1 = 1'b0; hfp0 = 1'b0; hfp1 = 1'b0; hlrc = '0;
        wq.delete();
        fq.delete();
        mon_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            wv  = (wq.size() > 0) && (wq[0].cyc == cyc);
            fv  = (fq.size() > 0) && (fq[0].cyc == cyc);
            xe0 = 1'b0;
            xe1 = 1'b0;
            if (wv) begin
                we  = wq.pop_front();
                hw0 = we.p0;  hw1 = we.p1;  xe0 = we.e0;  xe1 = we.e1;
            end
            if (fv) begin
                fe   = fq.pop_front();
                hlrc = fe.lrc;
                hfp0 = ^fe.lrc;
                hfp1 = ~(^fe.lrc);
            end
            check("word_valid0", b0.word_valid, wv);
            check("word_valid1", b1.word_valid, wv);
            check("word_par0", b0.word_par, hw0);
            check("word_par1", b1.word_par, hw1);
            check("err0", b0.err, xe0);
            check("err1", b1.err, xe1);
            check("err_cnt0", b0.err_cnt, ecnt0);
            check("err_cnt1", b1.err_cnt, ecnt1);
            check("frame_valid0", b0.frame_valid, fv);
            check("frame_valid1", b1.frame_valid, fv);
            check("frame_lrc0", b0.frame_lrc, hlrc);
            check("frame_lrc1", b1.frame_lrc, hlrc);
            check("frame_par0", b0.frame_par, hfp0);
            check("frame_par1", b1.frame_par, hfp1);
            check("busy0", b0.busy, ebusy);
            check("busy1", b1.busy, ebusy);
        end
    end

    logic [W-1:0] words [4];
    logic         pars  [4];
    logic         gap   [7];

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        words = '{8'h01, 8'h03, 8'h07, 8'h0F};
        pars  = '{1'b1, 1'b1, 1'b1, 1'b0};
        gap   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        do_reset();
        step(0, '0, 0, 0, 0);
        check("rst_err_cnt", b0.err_cnt, 0);
        check("rst_busy", b0.busy, 0);

        // back-to-back frame
        for (int i = 0; i < 4; i++) step(1, words[i], 0, 0, 0);
        step(0, '0, 0, 0, 0);
        check("lrc_0A", b0.frame_lrc, 8'h0A);
        check("fpar_odd", b1.frame_par, 1);

        // same words with idle gaps
        begin
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                if (gap[i]) begin
                    step(1, words[k], 0, 0, 0);
                    k++;
                end else begin
                    step(0, 8'hAA, 0, 0, 0);
                end
            end
        end
        step(0, '0, 0, 0, 0);

        // checking with one mismatch on the even instance
        for (int i = 0; i < 4; i++) step(1, words[i], pars[i], 1, 0);
        step(0, '0, 0, 0, 0);
        check("err_cnt_1", b0.err_cnt, 1);

        // drive the even-side counter into saturation
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] d;
            d = W'($urandom_range(0, 255));
            step(1, d, ~(^d), 1, 0);
        end
        step(0, '0, 0, 0, 0);
        check("err_cnt_sat", b0.err_cnt, 15);

        // abort after two words; the clearing word starts a new frame
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        step(1, 8'h07, 0, 0, 1);
        step(1, 8'hF0, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        check("lrc_F7", b0.frame_lrc, 8'hF7);
        check("fpar_F7", b0.frame_par, 1);

        // reset mid-frame, then a full frame from scratch
        step(1, 8'h55, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0);
        do_reset();
        step(0, '0, 0, 0, 0);
        check("midrst_busy", b0.busy, 0);
        check("midrst_lrc", b0.frame_lrc, 0);
        for (int i = 0; i < 4; i++) step(1, words[i], 0, 0, 0);
        step(0, '0, 0, 0, 0);

        // frame_clr without a word, then random traffic
        step(1, 8'h11, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0);

        check("word_queue_empty", wq.size(), 0);
        check("frame_queue_empty", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_stream_unit.md
Name: parity_stream_unit

Overview:
- Clocked, parametrised successor to the combinational 3-input XOR parity gate.
- Computes per-word parity on a stream of WIDTH-bit words.
- Accumulates a longitudinal (column-XOR) check word and overall parity across fixed-length frames.
- Optionally checks a received parity bit per word and counts errors. Sits between a data source and a link/storage stage.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- FRAME_LEN, 4, words per frame (>=2).
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity (output bit inverted).
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_data/in_par this cycle.
- in_data  input  WIDTH  data word.
- in_par  input  1  received parity bit for in_data (used when chk_en=1).
- chk_en  input  1  enable per-word parity checking.
- frame_clr  input  1  abort current frame accumulation.
- word_valid  output  1  one-cycle pulse: word_par is valid.
- word_par  output  1  parity of last accepted word (^in_data ^ ODD).
- frame_valid  output  1  one-cycle pulse: frame results are valid.
- frame_lrc  output  WIDTH  XOR of all FRAME_LEN words in the frame.
- frame_par  output  1  ^frame_lrc ^ ODD.
- err  output  1  one-cycle pulse on parity mismatch.
- err_cnt  output  ERR_W  saturating mismatch count.
- busy  output  1  high while a frame is partially accumulated (state ACCUM).

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, accumulator 0, word counter 0, state IDLE. Reset overrides every other input, including in_valid and frame_clr.
- Word accepted on any clk edge with in_valid=1. No backpressure; every valid word is consumed.
- Latency: 1 cycle. word_valid/word_par registered from the accepted word. word_valid is 0 in cycles after an idle (in_valid=0) edge; word_par holds its last value.
- Parity is computed the same way in all paths: p = XOR-reduce(in_data) XOR ODD.
- Check: if chk_en=1 and in_valid=1 and in_par != p, err=1 next cycle and err_cnt increments. err_cnt saturates at 2^ERR_W-1. err_cnt is cleared only by rst. chk_en=0 means err is never asserted.
- FSM states:
  - IDLE: counter=0, acc=0. A valid word sets acc=in_data, counter=1, and moves to ACCUM.
  - ACCUM: each valid word does acc ^= in_data and counter++. When the word making counter reach FRAME_LEN is accepted, the next cycle has frame_valid=1, frame_lrc = acc^in_data and frame_par computed from it. acc and counter then clear and the state returns to IDLE.
  - Back-to-back frames: the word after the final word is accepted in IDLE with no gap cycle required.
- frame_lrc/frame_par hold their values until the next frame_valid pulse.
- frame_clr=1 (no rst): acc and counter clear and no frame_valid is produced for the aborted frame. If in_valid=1 in the same cycle, that word still gets word_par/err processing and becomes word 1 of a new frame (state ACCUM, acc=in_data).
- in_valid gaps inside a frame do not advance the counter or modify acc.
- busy = (state == ACCUM).

Test Plan:
- WIDTH=8, FRAME_LEN=4, ODD=0; words 0x01,0x03,0x07,0x0F back-to-back -> word_par 1,0,1,0 on successive cycles; one cycle after the last word: frame_valid=1, frame_lrc=0x0A, frame_par=0, busy=0.
- Same words with ODD=1 -> word_par 0,1,0,1; frame_lrc=0x0A, frame_par=1.
- Same words with idle cycles interleaved (valid 1,0,1,0,0,1,1) -> identical results; frame_valid exactly once, one cycle after the 4th valid word.
- chk_en=1, in_par 1,1,1,0 with the words above -> err pulse only after word 0x03; err_cnt=1. Then 20 mismatched words -> err_cnt saturates at 15.
- frame_clr asserted with word 0x07 after 0x01,0x03 -> no frame_valid for the aborted frame. The new frame 0x07,0xF0,0x00,0x00 gives frame_lrc=0xF7, frame_par=1.
- rst asserted mid-frame after 2 words -> next cycle all outputs 0, busy=0. The next full frame computes correctly from zero.
